// File: rtl/dmem_pkg.sv
// Shared definitions for the banked data memory: access-width codes, FSM state, lane helpers.
// Latency: none (types and pure functions only).
// Backpressure: not applicable.
package dmem_pkg;

  // Load width codes; 101-111 decode as a full word.
  typedef enum logic [2:0] {
    RCTL_LB  = 3'b000,
    RCTL_LBU = 3'b001,
    RCTL_LH  = 3'b010,
    RCTL_LHU = 3'b011,
    RCTL_LW  = 3'b100
  } rctl_e;

  // Store width codes; 11 decodes as a full word.
  typedef enum logic [1:0] {
    WCTL_SW = 2'b00,
    WCTL_SH = 2'b01,
    WCTL_SB = 2'b10
  } wctl_e;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Byte-lane enables for a store of the given width at the given byte offset.
  function automatic logic [3:0] byte_enables(input logic [1:0] wctl, input logic [1:0] offset);
    logic [3:0] be;
    case (wctl)
      WCTL_SB: be = 4'b0001 << offset;
      WCTL_SH: be = 4'b0011 << offset;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  // Select the addressed byte/half from a full word and sign- or zero-extend it.
  function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] offset,
                                              input logic [2:0] rctl);
    logic [31:0] sh;
    logic [31:0] res;
    sh = word >> {offset, 3'b000};
    case (rctl)
      RCTL_LB:  res = {{24{sh[7]}}, sh[7:0]};
      RCTL_LBU: res = {24'h0, sh[7:0]};
      RCTL_LH:  res = {{16{sh[15]}}, sh[15:0]};
      RCTL_LHU: res = {16'h0, sh[15:0]};
      default:  res = word;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/dmem_bank.sv
// One byte lane of the data RAM: DEPTH x 8 array with write enable and registered read.
// Latency: read data registered one cycle after the index is presented (read-before-write).
// Backpressure: none; accepts a write and a read every cycle.
// Ports: clk; we (write strobe); idx (word index); wdata (byte to store); rdata (registered byte).
module dmem_bank #(
  parameter int DEPTH = 64,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] idx,
  input  logic [7:0]       wdata,
  output logic [7:0]       rdata
);

  logic [7:0] mem [DEPTH];

  // The array is deliberately not reset; clearing is done by the top-level INIT sequence.
  always_ff @(posedge clk) begin
    if (we) mem[idx] <= wdata;
    rdata <= mem[idx];
  end

endmodule

// File: rtl/dmem_banked.sv
// Byte-banked word data RAM with valid/ready request port, alignment/range checks, post-reset clear.
// Latency: response READ_LAT (1 or 2) cycles after acceptance; one request per cycle in RUN.
// Backpressure: req_ready low only while clearing after reset; responses cannot be stalled.
// Ports: clk, rst_n; req_valid/req_ready/req_we/req_rctl/req_wctl/req_addr/req_wdata (request);
//        rsp_valid/rsp_rdata/rsp_err (response pulse); init_done (clear sequence finished).
module dmem_banked
  import dmem_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DEPTH_WORDS    = 64,
  parameter int READ_LAT       = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_rctl,
  input  logic [1:0]        req_wctl,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              init_done
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH_WORDS - 1);

  state_e           state;
  logic [IDX_W-1:0] clr_cnt;

  // Request decode
  logic [1:0]       offset;
  logic [IDX_W-1:0] index;
  logic             out_of_range, misaligned, req_err, accept, do_store, clearing;
  logic [3:0]       be, bank_we;
  logic [31:0]      wdata_sh, bank_wdata, rd_word;
  logic [IDX_W-1:0] bank_idx;

  assign offset       = req_addr[1:0];
  assign index        = req_addr[2 +: IDX_W];
  assign out_of_range = (req_addr >> (IDX_W + 2)) != '0;
  assign misaligned   = req_we
      ? ((req_wctl == WCTL_SH) && offset[0]) ||
        ((req_wctl != WCTL_SH) && (req_wctl != WCTL_SB) && (offset != 2'b00))
      : (((req_rctl == RCTL_LH) || (req_rctl == RCTL_LHU)) && offset[0]) ||
        (req_rctl[2] && (offset != 2'b00));
  assign req_err  = misaligned || out_of_range;
  assign accept   = req_valid && req_ready;
  assign do_store = accept && req_we && !req_err;
  assign clearing = (state == ST_INIT) && (CLEAR_ON_RESET != 0);

  assign be         = byte_enables(req_wctl, offset);
  assign wdata_sh   = req_wdata << {offset, 3'b000};
  assign bank_we    = clearing ? 4'b1111 : (do_store ? be : 4'b0000);
  assign bank_wdata = clearing ? 32'h0 : wdata_sh;
  assign bank_idx   = clearing ? clr_cnt : index;

  for (genvar b = 0; b < 4; b++) begin : g_bank
    dmem_bank #(.DEPTH(DEPTH_WORDS), .IDX_W(IDX_W)) u_bank (
      .clk   (clk),
      .we    (bank_we[b]),
      .idx   (bank_idx),
      .wdata (bank_wdata[8*b +: 8]),
      .rdata (rd_word[8*b +: 8])
    );
  end

  // Control FSM: clear one word per cycle in INIT, then accept requests forever.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_INIT;
      clr_cnt   <= '0;
      req_ready <= 1'b0;
      init_done <= 1'b0;
    end else begin
      case (state)
        ST_INIT: begin
          if ((CLEAR_ON_RESET == 0) || (clr_cnt == LAST_IDX)) begin
            state     <= ST_RUN;
            req_ready <= 1'b1;
            init_done <= 1'b1;
          end else begin
            clr_cnt <= clr_cnt + 1'b1;
          end
        end
        ST_RUN: begin
          req_ready <= 1'b1;
          init_done <= 1'b1;
        end
      endcase
    end
  end

  // Stage 1 runs alongside the bank read registers; offset/width select from the registered word.
  logic       s1_valid, s1_err, s1_load;
  logic [1:0] s1_off;
  logic [2:0] s1_rctl;
  logic [31:0] ext_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_err   <= 1'b0;
      s1_load  <= 1'b0;
      s1_off   <= 2'b00;
      s1_rctl  <= 3'b000;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_err  <= req_err;
        s1_load <= !req_we;
        s1_off  <= offset;
        s1_rctl <= req_rctl;
      end
    end
  end

  assign ext_data = (s1_valid && s1_load && !s1_err) ? load_extend(rd_word, s1_off, s1_rctl) : 32'h0;

  if (READ_LAT == 2) begin : g_lat2
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rsp_valid <= 1'b0;
        rsp_err   <= 1'b0;
        rsp_rdata <= 32'h0;
      end else begin
        rsp_valid <= s1_valid;
        rsp_err   <= s1_valid && s1_err;
        rsp_rdata <= ext_data;
      end
    end
  end else begin : g_lat1
    assign rsp_valid = s1_valid;
    assign rsp_err   = s1_valid && s1_err;
    assign rsp_rdata = ext_data;
  end

endmodule

// File: tb/tb_dmem_banked.sv
// Scoreboard bench for dmem_banked: directed requests push expected responses, a monitor checks them.
// Latency: checks every response arrives READ_LAT cycles after its acceptance edge.
// Backpressure: driver waits (bounded) for req_ready before presenting a request.
module tb_dmem_banked;
  import dmem_pkg::*;

  localparam int LAT   = 2;
  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [2:0]  req_rctl = 3'b000;
  logic [1:0]  req_wctl = 2'b00;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        req_ready, rsp_valid, rsp_err, init_done;
  logic [31:0] rsp_rdata;

  dmem_banked #(
    .ADDR_W(32), .DEPTH_WORDS(DEPTH), .READ_LAT(LAT), .CLEAR_ON_RESET(1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_rctl  (req_rctl),
    .req_wctl  (req_wctl),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .init_done (init_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    acc_q[$];
  int    tests = 0;
  int    fails = 0;
  int    cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Record the cycle number of every acceptance edge.
  always @(posedge clk) begin
    cyc++;
    if (req_valid && req_ready) acc_q.push_back(cyc);
  end

  // Monitor: compare each presented response against the head of the scoreboard.
  always @(negedge clk) begin : monitor
    exp_t  e;
    string n;
    int    a;
    if (rsp_valid) begin
      if (exp_q.size() == 0 || acc_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_rsp: got rsp_valid=1 rdata=%h, expected no response", rsp_rdata);
      end else begin
        e = exp_q.pop_front();
        n = name_q.pop_front();
        a = acc_q.pop_front();
        check({n, "_data"}, rsp_rdata, e.rdata);
        check({n, "_err"}, 32'(rsp_err), 32'(e.err));
        check({n, "_lat"}, 32'(cyc - a), 32'(LAT - 1));
      end
    end
  end

  task automatic issue(input logic we, input logic [2:0] rctl, input logic [1:0] wctl,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_d, input logic exp_e, input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      tests++;
      fails++;
      $display("FAIL %s_ready_timeout: got req_ready=0, expected 1 within 200 cycles", name);
      req_valid = 1'b0;
      return;
    end
    req_valid = 1'b1;
    req_we    = we;
    req_rctl  = rctl;
    req_wctl  = wctl;
    req_addr  = addr;
    req_wdata = wdata;
    exp_q.push_back('{rdata: exp_d, err: exp_e});
    name_q.push_back(name);
  endtask

  task automatic ld(input logic [2:0] rctl, input logic [31:0] addr, input logic [31:0] exp_d,
                    input logic exp_e, input string name);
    issue(1'b0, rctl, 2'b00, addr, 32'h0, exp_d, exp_e, name);
  endtask

  task automatic st(input logic [1:0] wctl, input logic [31:0] addr, input logic [31:0] data,
                    input logic exp_e, input string name);
    issue(1'b1, 3'b000, wctl, addr, data, 32'h0, exp_e, name);
  endtask

  task automatic idle();
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    idle();
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({name, "_pending"}, 32'(exp_q.size()), 32'd0);
  endtask

  // Called at the negedge where rst_n was released; counts cycles until req_ready rises.
  task automatic wait_init(input string name);
    int n;
    n = 0;
    while (!req_ready && n < 200) begin
      @(negedge clk);
      n++;
      if (n == DEPTH / 2) check({name, "_done_mid"}, 32'(init_done), 32'd0);
    end
    check({name, "_cycles"}, 32'(n), 32'(DEPTH));
    check({name, "_done"}, 32'(init_done), 32'd1);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before 200000 time units");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    // Reset values
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_valid", 32'(rsp_valid), 32'd0);
    check("rst_rdata", rsp_rdata, 32'h0);
    check("rst_err", 32'(rsp_err), 32'd0);
    check("rst_done", 32'(init_done), 32'd0);
    rst_n = 1'b1;
    wait_init("init1");

    // Cleared memory
    ld(RCTL_LW, 32'h00, 32'h0, 1'b0, "clr_lo");
    ld(RCTL_LW, 32'hFC, 32'h0, 1'b0, "clr_hi");

    // Store/load widths
    st(WCTL_SW, 32'h10, 32'h80F1_7E02, 1'b0, "sw_10");
    ld(RCTL_LB,  32'h10, 32'h0000_0002, 1'b0, "lb_10");
    ld(RCTL_LB,  32'h13, 32'hFFFF_FF80, 1'b0, "lb_13");
    ld(RCTL_LBU, 32'h13, 32'h0000_0080, 1'b0, "lbu_13");
    ld(RCTL_LH,  32'h12, 32'hFFFF_80F1, 1'b0, "lh_12");
    ld(RCTL_LHU, 32'h12, 32'h0000_80F1, 1'b0, "lhu_12");
    ld(RCTL_LW,  32'h10, 32'h80F1_7E02, 1'b0, "lw_10");
    ld(3'b111,   32'h10, 32'h80F1_7E02, 1'b0, "lw7_10");
    ld(RCTL_LBU, 32'h11, 32'h0000_007E, 1'b0, "lbu_11");

    // Partial stores
    st(WCTL_SW, 32'h20, 32'hFFFF_FFFF, 1'b0, "sw_20");
    st(WCTL_SB, 32'h21, 32'h0000_00AB, 1'b0, "sb_21");
    st(WCTL_SH, 32'h22, 32'h0000_1234, 1'b0, "sh_22");
    ld(RCTL_LW, 32'h20, 32'h1234_ABFF, 1'b0, "lw_20");
    st(2'b11,   32'h30, 32'hCAFE_F00D, 1'b0, "sw3_30");
    ld(RCTL_LW, 32'h30, 32'hCAFE_F00D, 1'b0, "lw_30");

    // Errors
    ld(RCTL_LW,  32'h11, 32'h0, 1'b1, "lw_mis");
    ld(RCTL_LH,  32'h11, 32'h0, 1'b1, "lh_mis");
    st(WCTL_SH,  32'h23, 32'h0000_5555, 1'b1, "sh_mis");
    st(WCTL_SW,  32'h22, 32'h0000_5555, 1'b1, "sw_mis");
    ld(RCTL_LW,  32'h20, 32'h1234_ABFF, 1'b0, "lw_20_kept");
    ld(RCTL_LW,  32'h100, 32'h0, 1'b1, "lw_oor");
    ld(RCTL_LBU, 32'h1001, 32'h0, 1'b1, "lbu_oor");
    st(WCTL_SB,  32'h8000_0010, 32'h0000_0077, 1'b1, "sb_oor");
    ld(RCTL_LW,  32'h10, 32'h80F1_7E02, 1'b0, "lw_10_kept");

    // Pipelining: alternating sw/lw to one word, back to back
    st(WCTL_SW, 32'h40, 32'h1111_1111, 1'b0, "p_sw0");
    ld(RCTL_LW, 32'h40, 32'h1111_1111, 1'b0, "p_lw0");
    st(WCTL_SW, 32'h40, 32'hA5A5_0F0F, 1'b0, "p_sw1");
    ld(RCTL_LW, 32'h40, 32'hA5A5_0F0F, 1'b0, "p_lw1");
    st(WCTL_SW, 32'h40, 32'h0000_0000, 1'b0, "p_sw2");
    ld(RCTL_LW, 32'h40, 32'h0000_0000, 1'b0, "p_lw2");
    st(WCTL_SW, 32'h40, 32'hDEAD_BEEF, 1'b0, "p_sw3");
    ld(RCTL_LW, 32'h40, 32'hDEAD_BEEF, 1'b0, "p_lw3");
    drain("main");

    // Reset mid-stream: two loads in flight, then reset
    ld(RCTL_LW, 32'h10, 32'h80F1_7E02, 1'b0, "inflight0");
    ld(RCTL_LW, 32'h20, 32'h1234_ABFF, 1'b0, "inflight1");
    @(posedge clk);
    #2;
    check("inflight_valid", 32'(rsp_valid), 32'd1);
    rst_n = 1'b0;
    req_valid = 1'b0;
    #1;
    check("rst_drop_valid", 32'(rsp_valid), 32'd0);
    check("rst_drop_ready", 32'(req_ready), 32'd0);
    exp_q.delete();
    name_q.delete();
    acc_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_init("init2");
    ld(RCTL_LW, 32'h20, 32'h0, 1'b0, "reclr_20");
    ld(RCTL_LW, 32'h10, 32'h0, 1'b0, "reclr_10");
    drain("end");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
